// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and the
//   counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width; a 1-bit adder still needs a 1-bit counter.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit
//   1-bit combinational full adder built from two half adders plus an OR.
//   Ports: a, b, cin (in) -> s, cout (out)
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder
//   1-bit combinational half adder.
//   Ports: a, b (in)  -> s = a^b, c = a&b (out)
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted in IDLE, added LSB-first
//   through one full-adder cell over WIDTH RUN cycles, and the result is held
//   in DONE until the consumer handshakes.
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port
//   (sub=1 computes A + ~B + 1; carry_out=1 then means A >= B unsigned).
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   operand handshake (a, b, sub sampled on accept)
//     out_valid/out_ready result handshake (sum, carry_out)
//     busy                high while in RUN or DONE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int unsigned     CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic sub_in;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_c;

    full_adder_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_sh_nxt = fa_s;
    end else begin : g_sum_wn
        assign sum_sh_nxt = {fa_s, sum_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        // Subtraction is A + ~B + 1: invert B once at load, carry-in of 1.
                        b_sh_q   <= b ^ {WIDTH{sub_in}};
                        carry_q  <= sub_in;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= sum_sh_nxt;
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sum       <= sum_sh_nxt;
                        carry_out <= fa_c;
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
